// File: rtl/jtdd_pkg.sv
// Shared definitions for the ROM arbiter slice.
// Holds the 2-bit client ids, the arbiter FSM state encoding and the
// fixed-priority pick helper (main > char > scr > obj).
package jtdd_pkg;

    typedef logic [1:0] client_id_t;

    localparam client_id_t ID_MAIN = 2'd0;
    localparam client_id_t ID_CHAR = 2'd1;
    localparam client_id_t ID_SCR  = 2'd2;
    localparam client_id_t ID_OBJ  = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

    // Lowest client id wins; only meaningful when pend is non-zero.
    function automatic client_id_t prio_pick(input logic [3:0] pend);
        if (pend[0])      return ID_MAIN;
        else if (pend[1]) return ID_CHAR;
        else if (pend[2]) return ID_SCR;
        else              return ID_OBJ;
    endfunction

endpackage

// File: rtl/jtdd_rom_arb_if.sv
// SDRAM-side bus of the ROM arbiter.
//   sdram_req/sdram_addr : read request and 22-bit word address (arbiter -> SDRAM)
//   sdram_ack            : request accepted (SDRAM -> arbiter)
//   data_rdy/data_read   : returned 32-bit word strobe and data (SDRAM -> arbiter)
//   refresh_en           : SDRAM may refresh, arbiter is idle (arbiter -> SDRAM)
// master = arbiter side, slave = SDRAM controller side.
interface jtdd_rom_arb_if;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;
    logic        refresh_en;

    modport master (
        output sdram_req, sdram_addr, refresh_en,
        input  sdram_ack, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr, refresh_en,
        output sdram_ack, data_rdy, data_read
    );
endinterface

// File: rtl/jtdd_rom_entry.sv
// One-word cache entry for a single ROM client.
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : synchronous invalidate (valid only; tag/data kept)
//   we              : write tag/data and set valid
//   wr_addr/wr_data : address tag and word to store
//   cs/addr         : client request and current address
//   data/ok         : cached word, hit indication (cs & valid & tag match)
module jtdd_rom_entry #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [31:0]   data,
    output logic          ok
);
    logic [AW-1:0] tag;
    logic          valid;

    // Invalidate wins over a simultaneous write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (we) begin
            tag   <= wr_addr;
            data  <= wr_data;
            valid <= 1'b1;
        end
    end

    assign ok = cs && valid && (tag == addr);

endmodule

// File: rtl/jtdd_rom_arb.sv
// ROM arbiter: four clients (main, char, scr, obj) each with a one-word
// cache share a single SDRAM read port.
//   clk, rst            : clock, asynchronous active-high reset
//   downloading         : ROM load in progress, arbiter held idle, caches flushed
//   loop_rst            : synchronous flush of all cache entries, FSM to IDLE
//   X_cs/X_addr         : client read request and word address
//   X_data/X_ok         : cached word and hit flag for the current X_addr
//   sdram (master)      : SDRAM request/ack/data bus plus refresh_en
module jtdd_rom_arb
    import jtdd_pkg::*;
#(
    parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
    parameter logic [21:0] CHAR_OFFSET = 22'h01_0000,
    parameter logic [21:0] SCR_OFFSET  = 22'h01_4000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h03_4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        loop_rst,
    input  logic        main_cs,
    input  logic [14:0] main_addr,
    output logic [31:0] main_data,
    output logic        main_ok,
    input  logic        char_cs,
    input  logic [14:0] char_addr,
    output logic [31:0] char_data,
    output logic        char_ok,
    input  logic        scr_cs,
    input  logic [15:0] scr_addr,
    output logic [31:0] scr_data,
    output logic        scr_ok,
    input  logic        obj_cs,
    input  logic [15:0] obj_addr,
    output logic [31:0] obj_data,
    output logic        obj_ok,
    jtdd_rom_arb_if.master sdram
);
    logic [3:0]  cs_v;
    logic [3:0]  ok_v;
    logic [3:0]  pend;
    logic [15:0] addr_v [4];
    logic [21:0] off_v  [4];
    logic [31:0] data_v [4];

    state_t      state;
    logic        req_r;
    logic [21:0] addr_r;
    client_id_t  gnt;
    logic [15:0] gnt_addr;
    client_id_t  pick;
    logic        any_pend;
    logic        done;
    logic        we;
    logic        clr;

    assign cs_v = {obj_cs, scr_cs, char_cs, main_cs};

    // 15-bit clients are zero-extended so every entry uses a 16-bit tag.
    assign addr_v[ID_MAIN] = {1'b0, main_addr};
    assign addr_v[ID_CHAR] = {1'b0, char_addr};
    assign addr_v[ID_SCR]  = scr_addr;
    assign addr_v[ID_OBJ]  = obj_addr;

    assign off_v[ID_MAIN] = MAIN_OFFSET;
    assign off_v[ID_CHAR] = CHAR_OFFSET;
    assign off_v[ID_SCR]  = SCR_OFFSET;
    assign off_v[ID_OBJ]  = OBJ_OFFSET;

    assign pend     = cs_v & ~ok_v;
    assign any_pend = |pend;
    assign pick     = prio_pick(pend);

    // Transfer completes on data_rdy in WAIT_RDY, or on ack+rdy together in WAIT_ACK.
    assign done = ((state == WAIT_RDY) && sdram.data_rdy) ||
                  ((state == WAIT_ACK) && sdram.sdram_ack && sdram.data_rdy);
    assign clr  = downloading || loop_rst;
    assign we   = done && !clr;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_entry
            jtdd_rom_entry #(.AW(16)) u_entry (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr),
                .we      (we && (gnt == client_id_t'(i))),
                .wr_addr (gnt_addr),
                .wr_data (sdram.data_read),
                .cs      (cs_v[i]),
                .addr    (addr_v[i]),
                .data    (data_v[i]),
                .ok      (ok_v[i])
            );
        end
    endgenerate

    // --- request FSM: one outstanding SDRAM read at a time ---
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_r    <= 1'b0;
            addr_r   <= '0;
            gnt      <= ID_MAIN;
            gnt_addr <= '0;
        end else if (clr) begin
            state <= IDLE;
            req_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        gnt      <= pick;
                        gnt_addr <= addr_v[pick];
                        addr_r   <= off_v[pick] + {6'd0, addr_v[pick]};
                        req_r    <= 1'b1;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram.sdram_ack) begin
                        req_r <= 1'b0;
                        state <= sdram.data_rdy ? IDLE : WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (sdram.data_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sdram.sdram_req  = req_r;
    assign sdram.sdram_addr = addr_r;
    // Gated by rst so refresh stays off while reset is held.
    assign sdram.refresh_en = !rst && (state == IDLE) && !any_pend && !downloading;

    assign main_data = data_v[ID_MAIN];
    assign char_data = data_v[ID_CHAR];
    assign scr_data  = data_v[ID_SCR];
    assign obj_data  = data_v[ID_OBJ];
    assign main_ok   = ok_v[ID_MAIN];
    assign char_ok   = ok_v[ID_CHAR];
    assign scr_ok    = ok_v[ID_SCR];
    assign obj_ok    = ok_v[ID_OBJ];

endmodule

// File: tb/tb_jtdd_rom_arb.sv
module tb_jtdd_rom_arb;

    localparam logic [21:0] MAIN_OFF = 22'h00_0000;
    localparam logic [21:0] CHAR_OFF = 22'h01_0000;
    localparam logic [21:0] SCR_OFF  = 22'h01_4000;
    localparam logic [21:0] OBJ_OFF  = 22'h03_4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, downloading, loop_rst;
    logic        main_cs, char_cs, scr_cs, obj_cs;
    logic [14:0] main_addr, char_addr;
    logic [15:0] scr_addr, obj_addr;
    logic [31:0] main_data, char_data, scr_data, obj_data;
    logic        main_ok, char_ok, scr_ok, obj_ok;

    jtdd_rom_arb_if sd();

    jtdd_rom_arb #(
        .MAIN_OFFSET(MAIN_OFF), .CHAR_OFFSET(CHAR_OFF),
        .SCR_OFFSET(SCR_OFF),   .OBJ_OFFSET(OBJ_OFF)
    ) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .loop_rst(loop_rst),
        .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
        .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
        .scr_cs(scr_cs),   .scr_addr(scr_addr),   .scr_data(scr_data),   .scr_ok(scr_ok),
        .obj_cs(obj_cs),   .obj_addr(obj_addr),   .obj_data(obj_data),   .obj_ok(obj_ok),
        .sdram(sd)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one cache line per client, plus the current inputs.
    logic [21:0] off   [4];
    bit          mvalid[4];
    logic [15:0] mtag  [4];
    logic [31:0] mdata [4];
    bit          ccs   [4];
    logic [15:0] caddr [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int id, input bit cs, input logic [15:0] a);
        case (id)
            0: begin main_cs = cs; main_addr = a[14:0]; caddr[0] = {1'b0, a[14:0]}; end
            1: begin char_cs = cs; char_addr = a[14:0]; caddr[1] = {1'b0, a[14:0]}; end
            2: begin scr_cs  = cs; scr_addr  = a;       caddr[2] = a; end
            default: begin obj_cs = cs; obj_addr = a;   caddr[3] = a; end
        endcase
        ccs[id] = cs;
    endtask

    task automatic clear_clients();
        for (int k = 0; k < 4; k++) set_client(k, 1'b0, 16'h0);
    endtask

    function automatic bit dut_ok(input int id);
        case (id)
            0: return main_ok;
            1: return char_ok;
            2: return scr_ok;
            default: return obj_ok;
        endcase
    endfunction

    function automatic logic [31:0] dut_data(input int id);
        case (id)
            0: return main_data;
            1: return char_data;
            2: return scr_data;
            default: return obj_data;
        endcase
    endfunction

    function automatic bit m_ok(input int id);
        return ccs[id] && mvalid[id] && (mtag[id] == caddr[id]);
    endfunction

    // First pending client in priority order, -1 if none.
    function automatic int m_pick();
        for (int k = 0; k < 4; k++)
            if (ccs[k] && !m_ok(k)) return k;
        return -1;
    endfunction

    function automatic logic [21:0] exp_addr(input int id);
        return off[id] + {6'd0, caddr[id]};
    endfunction

    function automatic logic [3:0] dut_oks();
        return {obj_ok, scr_ok, char_ok, main_ok};
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 4; k++) mvalid[k] = 1'b0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (sd.sdram_req === 1'b1) begin
                got = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // SDRAM responder: ack after ack_dly cycles, data rdy_dly cycles after ack
    // (rdy_dly == 0 means ack and data in the same cycle).
    task automatic serve(input int ack_dly, input int rdy_dly, input logic [31:0] d);
        repeat (ack_dly) tick();
        sd.sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            sd.data_rdy  = 1'b1;
            sd.data_read = d;
        end
        tick();
        sd.sdram_ack = 1'b0;
        sd.data_rdy  = 1'b0;
        if (rdy_dly > 0) begin
            repeat (rdy_dly - 1) tick();
            sd.data_rdy  = 1'b1;
            sd.data_read = d;
            tick();
            sd.data_rdy = 1'b0;
        end
    endtask

    task automatic fetch(input int id, input int ack_dly, input int rdy_dly, input logic [31:0] d,
                         output bit got, output logic [21:0] seen);
        wait_req(got);
        seen = sd.sdram_addr;
        if (got) begin
            mtag[id] = caddr[id];
            serve(ack_dly, rdy_dly, d);
            mvalid[id] = 1'b1;
            mdata[id]  = d;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0;
        sd.sdram_ack = 1'b0; sd.data_rdy = 1'b0; sd.data_read = 32'h0;
        clear_clients();
        set_client(0, 1'b1, 16'h0000);
        tick(); tick();
        n_cmp++;
        if ({sd.sdram_req, sd.sdram_addr, sd.refresh_en} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_bus: req=%b addr=%h refresh=%b required 0/0/0",
                     sd.sdram_req, sd.sdram_addr, sd.refresh_en);
        end
        n_cmp++;
        if (dut_oks() !== 4'h0) begin
            n_err++; $display("FAIL reset_ok: got %b required 0000", dut_oks());
        end
        n_cmp++;
        if ({main_data, char_data, scr_data, obj_data} !== 128'h0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h %h required 0",
                              main_data, char_data, scr_data, obj_data);
        end
        for (int k = 0; k < 4; k++) begin mvalid[k] = 0; mtag[k] = 0; mdata[k] = 0; end
        clear_clients();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (sd.refresh_en !== 1'b1) begin
            n_err++; $display("FAIL idle_refresh: got %b required 1", sd.refresh_en);
        end
    endtask

    task automatic test_char_hit();
        bit got; logic [21:0] seen; bit bad;
        clear_clients();
        set_client(1, 1'b1, 16'h0123);
        wait_req(got);
        seen = sd.sdram_addr;
        mtag[1] = caddr[1];
        n_cmp++;
        if (!got || seen !== 22'h01_0123) begin
            n_err++; $display("FAIL char_addr: got %b/%h required 1/010123", got, seen);
        end
        if (got) begin
            serve(2, 4, 32'hDEADBEEF);
            mvalid[1] = 1'b1; mdata[1] = 32'hDEADBEEF;
        end
        n_cmp++;
        if (char_ok !== 1'b1 || char_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL char_hit: ok=%b data=%h required 1/deadbeef", char_ok, char_data);
        end
        set_client(1, 1'b0, 16'h0123);
        tick();
        set_client(1, 1'b1, 16'h0123);
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (sd.sdram_req !== 1'b0 || char_ok !== 1'b1) bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (bad) begin
            n_err++; $display("FAIL char_rehit: req=%b ok=%b required 0/1", sd.sdram_req, char_ok);
        end
    endtask

    task automatic test_priority();
        bit got; logic [21:0] seen;
        clear_clients();
        set_client(0, 1'b1, 16'($urandom_range(16'h100, 16'h7FFF)));
        set_client(3, 1'b1, 16'($urandom_range(16'h100, 16'hFFFF)));
        #1;
        n_cmp++;
        if (sd.refresh_en !== 1'b0) begin
            n_err++; $display("FAIL prio_refresh: got %b required 0", sd.refresh_en);
        end
        fetch(0, 1, 2, $urandom, got, seen);
        n_cmp++;
        if (!got || seen !== exp_addr(0)) begin
            n_err++; $display("FAIL prio_main: got %b/%h required 1/%h", got, seen, exp_addr(0));
        end
        n_cmp++;
        if (sd.sdram_req !== 1'b0 || obj_ok !== 1'b0) begin
            n_err++; $display("FAIL prio_gap: req=%b obj_ok=%b required 0/0", sd.sdram_req, obj_ok);
        end
        fetch(3, 0, 0, $urandom, got, seen);
        n_cmp++;
        if (!got || seen !== exp_addr(3)) begin
            n_err++; $display("FAIL prio_obj: got %b/%h required 1/%h", got, seen, exp_addr(3));
        end
        n_cmp++;
        if ({main_ok, obj_ok} !== 2'b11 || main_data !== mdata[0] || obj_data !== mdata[3]) begin
            n_err++; $display("FAIL prio_data: ok=%b%b data=%h/%h required 11 %h/%h",
                              main_ok, obj_ok, main_data, obj_data, mdata[0], mdata[3]);
        end
    endtask

    task automatic test_addr_change();
        bit got; logic [21:0] seen;
        clear_clients();
        set_client(2, 1'b1, 16'h0010);
        wait_req(got);
        seen = sd.sdram_addr;
        n_cmp++;
        if (!got || seen !== 22'h01_4010) begin
            n_err++; $display("FAIL scr_first: got %b/%h required 1/014010", got, seen);
        end
        sd.sdram_ack = 1'b1;
        tick();
        sd.sdram_ack = 1'b0;
        set_client(2, 1'b1, 16'h0011);
        tick();
        sd.data_rdy = 1'b1; sd.data_read = 32'hA5A5_0010;
        tick();
        sd.data_rdy = 1'b0;
        mvalid[2] = 1'b1; mtag[2] = 16'h0010; mdata[2] = 32'hA5A5_0010;
        n_cmp++;
        if (scr_ok !== 1'b0) begin
            n_err++; $display("FAIL scr_stale: got %b required 0", scr_ok);
        end
        fetch(2, 1, 1, 32'h5A5A_0011, got, seen);
        n_cmp++;
        if (!got || seen !== 22'h01_4011) begin
            n_err++; $display("FAIL scr_second: got %b/%h required 1/014011", got, seen);
        end
        n_cmp++;
        if (scr_ok !== 1'b1 || scr_data !== 32'h5A5A_0011) begin
            n_err++; $display("FAIL scr_hit: ok=%b data=%h required 1/5a5a0011", scr_ok, scr_data);
        end
    endtask

    task automatic fill_all(input string tag);
        bit got; logic [21:0] seen; int p;
        for (int n = 0; n < 6; n++) begin
            p = m_pick();
            if (p < 0) break;
            fetch(p, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, got, seen);
            n_cmp++;
            if (!got || seen !== exp_addr(p)) begin
                n_err++; $display("FAIL %s_fetch%0d: got %b/%h required 1/%h", tag, p, got, seen, exp_addr(p));
            end
        end
        n_cmp++;
        if (dut_oks() !== 4'hF) begin
            n_err++; $display("FAIL %s_allok: got %b required 1111", tag, dut_oks());
        end
    endtask

    task automatic test_download();
        bit bad;
        clear_clients();
        set_client(0, 1'b1, 16'h00AA);
        set_client(1, 1'b1, 16'h0BB0);
        set_client(2, 1'b1, 16'hC0C0);
        set_client(3, 1'b1, 16'hFFFF);
        fill_all("dl_pre");
        downloading = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (dut_oks() !== 4'h0 || sd.sdram_req !== 1'b0 || sd.refresh_en !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++; $display("FAIL download_hold: ok=%b req=%b refresh=%b required 0000/0/0",
                              dut_oks(), sd.sdram_req, sd.refresh_en);
        end
        m_clear();
        downloading = 1'b0;
        fill_all("dl_post");
    endtask

    task automatic test_loop_rst();
        bit got;
        clear_clients();
        set_client(0, 1'b1, 16'h0321);
        wait_req(got);
        n_cmp++;
        if (!got || sd.sdram_addr !== exp_addr(0)) begin
            n_err++; $display("FAIL lrst_req: got %b/%h required 1/%h", got, sd.sdram_addr, exp_addr(0));
        end
        sd.sdram_ack = 1'b1;
        tick();
        sd.sdram_ack = 1'b0;
        loop_rst = 1'b1;
        tick();
        loop_rst = 1'b0;
        m_clear();
        sd.data_rdy = 1'b1; sd.data_read = 32'h12345678;
        tick();
        sd.data_rdy = 1'b0;
        n_cmp++;
        if (main_ok !== 1'b0 || main_data !== mdata[0]) begin
            n_err++; $display("FAIL lrst_ignore: ok=%b data=%h required 0/%h", main_ok, main_data, mdata[0]);
        end
        n_cmp++;
        if (sd.sdram_req !== 1'b1 || sd.sdram_addr !== exp_addr(0)) begin
            n_err++; $display("FAIL lrst_restart: req=%b addr=%h required 1/%h",
                              sd.sdram_req, sd.sdram_addr, exp_addr(0));
        end
        mtag[0] = caddr[0];
        serve(1, 1, 32'h0BAD_F00D);
        mvalid[0] = 1'b1; mdata[0] = 32'h0BAD_F00D;
        n_cmp++;
        if (main_ok !== 1'b1 || main_data !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL lrst_refetch: ok=%b data=%h required 1/0badf00d", main_ok, main_data);
        end
    endtask

    task automatic test_async_reset();
        bit got;
        clear_clients();
        set_client(3, 1'b1, 16'h4242);
        wait_req(got);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (!got || {sd.sdram_req, sd.sdram_addr, sd.refresh_en} !== 24'h0 || obj_ok !== 1'b0 ||
            {main_data, char_data, scr_data, obj_data} !== 128'h0) begin
            n_err++; $display("FAIL async_rst: got=%b req=%b addr=%h refresh=%b obj_ok=%b required 1/0/0/0/0",
                              got, sd.sdram_req, sd.sdram_addr, sd.refresh_en, obj_ok);
        end
        for (int k = 0; k < 4; k++) begin mvalid[k] = 0; mtag[k] = 0; mdata[k] = 0; end
        #2;
        sd.data_rdy = 1'b1; sd.data_read = 32'hFEED_FACE;
        rst = 1'b0;
        tick();
        sd.data_rdy = 1'b0;
        n_cmp++;
        if (obj_ok !== 1'b0 || sd.sdram_req !== 1'b1 || sd.sdram_addr !== exp_addr(3)) begin
            n_err++; $display("FAIL async_restart: ok=%b req=%b addr=%h required 0/1/%h",
                              obj_ok, sd.sdram_req, sd.sdram_addr, exp_addr(3));
        end
        mtag[3] = caddr[3];
        serve(0, 2, 32'h0000_4242);
        mvalid[3] = 1'b1; mdata[3] = 32'h0000_4242;
        n_cmp++;
        if (obj_ok !== 1'b1 || obj_data !== 32'h0000_4242) begin
            n_err++; $display("FAIL async_refetch: ok=%b data=%h required 1/00004242", obj_ok, obj_data);
        end
    endtask

    task automatic test_random();
        bit got; logic [21:0] seen; int p;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 4; k++)
                set_client(k, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)));
            #1;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (dut_ok(k) !== m_ok(k) || (m_ok(k) && dut_data(k) !== mdata[k])) begin
                    n_err++; $display("FAIL rnd%0d_ok%0d: ok=%b data=%h required %b/%h",
                                      r, k, dut_ok(k), dut_data(k), m_ok(k), mdata[k]);
                end
            end
            for (int n = 0; n < 5; n++) begin
                p = m_pick();
                if (p < 0) break;
                fetch(p, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, got, seen);
                n_cmp++;
                if (!got || seen !== exp_addr(p) || dut_ok(p) !== 1'b1 || dut_data(p) !== mdata[p]) begin
                    n_err++; $display("FAIL rnd%0d_fetch%0d: got=%b addr=%h ok=%b data=%h required 1/%h/1/%h",
                                      r, p, got, seen, dut_ok(p), dut_data(p), exp_addr(p), mdata[p]);
                end
            end
            n_cmp++;
            if (sd.refresh_en !== 1'b1 || sd.sdram_req !== 1'b0) begin
                n_err++; $display("FAIL rnd%0d_idle: refresh=%b req=%b required 1/0", r, sd.refresh_en, sd.sdram_req);
            end
            tick();
        end
    endtask

    initial begin
        off[0] = MAIN_OFF; off[1] = CHAR_OFF; off[2] = SCR_OFF; off[3] = OBJ_OFF;
        test_reset();
        test_char_hit();
        test_priority();
        test_addr_change();
        test_download();
        test_loop_rst();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/jtdd_rom_arb.md
JTDD_ROM_ARB -- requirements
Module: jtdd_rom_arb

Interface
REQ-001 SHALL have parameters: MAIN_OFFSET default 22'h00_0000 (SDRAM word base of main CPU ROM); CHAR_OFFSET default 22'h01_0000 (char ROM base); SCR_OFFSET default 22'h01_4000 (scroll ROM base); OBJ_OFFSET default 22'h03_4000 (object ROM base).
REQ-002 SHALL have ports, clock and reset first: clk in 1 system clock; rst in 1 reset, asynchronous and active-high.
REQ-003 SHALL have: downloading in 1, ROM load in progress; loop_rst in 1, synchronous clear of all cache state.
REQ-004 SHALL have per client X in {main, char, scr, obj}: X_cs in 1, read request; X_addr in 15 (main, char) or 16 (scr, obj), word address; X_data out 32, returned word; X_ok out 1, X_data valid for current X_addr.
REQ-005 SHALL have SDRAM side: sdram_req out 1; sdram_addr out 22; sdram_ack in 1; data_rdy in 1; data_read in 32; refresh_en out 1.

Function
REQ-006 SHALL keep per client one cache entry: tag (last fetched address), 32-bit data, valid bit.
REQ-007 SHALL assert X_ok combinationally from registers iff X_cs, valid[X], and tag[X]==X_addr; X_data SHALL always present the cached data.
REQ-008 SHALL consider client X pending iff X_cs and not X_ok.
REQ-009 SHALL use FSM states IDLE, WAIT_ACK, WAIT_RDY.
REQ-010 IDLE: if not downloading and any client pending, grant by fixed priority main > char > scr > obj, latch granted id and address, drive sdram_addr = offset + zero-extended address, set sdram_req, go WAIT_ACK next cycle.
REQ-011 WAIT_ACK: hold sdram_req and sdram_addr stable; on sdram_ack clear sdram_req next cycle, go WAIT_RDY.
REQ-012 WAIT_RDY: on data_rdy write data_read, latched address as tag, valid=1 into the granted entry; return to IDLE; total minimum latency cs-to-ok = 3 cycles plus SDRAM delay.
REQ-013 sdram_ack and data_rdy in the same WAIT_ACK cycle SHALL complete the transfer directly (write entry, go IDLE).
REQ-014 Client address change or cs drop mid-transaction SHALL NOT abort; result is cached under the latched address and ok follows REQ-007; a new request follows in IDLE.
REQ-015 A new grant SHALL NOT be issued in the same cycle a transfer completes; at most one outstanding request.
REQ-016 refresh_en SHALL be 1 only in IDLE with no pending client and downloading low.
REQ-017 downloading high SHALL clear all valid bits every cycle, drop sdram_req, force IDLE; refresh_en 0.
REQ-018 loop_rst SHALL clear all valid bits and force IDLE on the next edge, dropping any outstanding request; a data_rdy arriving later in IDLE SHALL be ignored.
REQ-019 address arithmetic SHALL be 22-bit, modulo 2^22, no overflow flag.

Reset
REQ-020 On rst: state IDLE, sdram_req 0, sdram_addr 0, all valid 0, tags 0, data 0, refresh_en 0, all X_ok 0.
REQ-021 Reset deassertion mid-transaction SHALL restart in IDLE; stale data_rdy ignored.

Structure
REQ-022 Client ids (2-bit) and FSM state encoding SHALL live in shared package jtdd_pkg; offsets stay module parameters.
REQ-023 One sub-module jtdd_rom_entry (tag/data/valid register plus ok compare) SHALL be instantiated four times.

Verification
REQ-024 char_cs=1, char_addr=15'h0123, SDRAM acks after 2 cycles, data_rdy 4 later with 32'hDEADBEEF -> sdram_addr=22'h01_0123; char_ok=1, char_data=32'hDEADBEEF; second access same address gives no sdram_req.
REQ-025 main and obj pending in same cycle -> main granted first (sdram_addr=MAIN_OFFSET+main_addr), obj granted next IDLE.
REQ-026 scr_addr changes 16'h0010->16'h0011 in WAIT_RDY -> scr_ok stays 0 after completion; second request to 22'h01_4011 issued; scr_ok=1 after its data_rdy.
REQ-027 downloading pulse 5 cycles after all four cached -> all X_ok 0, sdram_req 0 throughout, refresh_en 0; refetch after release.
REQ-028 loop_rst in WAIT_RDY then data_rdy with 32'h12345678 -> no entry written, all ok 0, FSM restarts requests.
REQ-029 rst asserted asynchronously mid WAIT_ACK -> sdram_req 0 same cycle without clock edge; all outputs at reset values.
